sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter that drives the single-bit stream consumed by the sequence detectors. A pattern word, active length and repeat count are captured through a valid/ready start handshake. The block then shifts the active field out MSB-first, one bit per clock, repeating the pattern back-to-back the requested number of times. It is the stimulus source for detector bring-up on the bench and for on-chip self-test.

Parameters:
WIDTH, 8, maximum pattern length in bits (≥2).
LEN_W, $clog2(WIDTH+1), width of the len port (derived; do not override).
REPS_W, 4, width of the repeat-count port.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
start_valid  input  1  request to start a burst.
start_ready  output  1  high only in IDLE; a burst starts when start_valid && start_ready at a rising edge.
pattern  input  WIDTH  pattern word; bit len-1 is sent first, bit 0 last.
len  input  LEN_W  active pattern length; 0 means empty burst; values above WIDTH are clamped to WIDTH.
reps  input  REPS_W  repetition count; 0 is treated as 1.
abort  input  1  terminates a burst in progress.
x  output  1  serial data bit; 0 whenever x_valid is 0.
x_valid  output  1  x carries a pattern bit this cycle.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse on normal burst completion.

Behaviour:
- Reset (async, resetn=0): state=IDLE; x=0, x_valid=0, busy=0, done=0, start_ready=1. All internal registers are cleared.
- All outputs are register-driven (flops or a decode of state flops only), with no combinational path from inputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On a handshake, capture pattern, clamped len and effective reps (0→1).
  - If clamped len=0, go to DONE; x_valid never rises.
  - Otherwise go to SHIFT with bit index = len-1 and reps_left = reps.
  - start_valid in any other state is ignored; the inputs are not sampled.
- SHIFT:
  - x_valid=1 and x=pat_q[idx], starting the cycle after the handshake edge (latency 1).
  - Each cycle:
    - If idx>0, idx decrements.
    - Else if reps_left>1, idx reloads to len-1 and reps_left decrements. There is no gap between repetitions.
    - Else go to DONE.
  - x_valid stays high for exactly len*reps consecutive cycles.
- DONE: done=1 for exactly one cycle, x_valid=0, then IDLE. start_ready is 0 in DONE.
- abort:
  - Sampled in SHIFT only: the next state is IDLE, x_valid drops on the next cycle, and done is not pulsed.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the last-bit transition to DONE.
- Reset asserted mid-burst: outputs go immediately (asynchronously) to their reset values, and no done pulse follows.
- Width rules:
  - idx is LEN_W bits; reps_left is REPS_W bits.
  - The len clamp compares against WIDTH at full LEN_W width.
  - A bit select with idx ≥ WIDTH is unreachable by construction.

Decomposition:
- Shared package seqgen_pkg holds:
  - The state enum (IDLE, SHIFT, DONE) as 2-bit localparams.
  - The default WIDTH/REPS_W constants, which the detector bench also uses.
- No sub-module is needed. The bit-index and repeat counters live inline. The block is a single module of about 150 lines.

Test Plan:
- Reset, then pattern=8'b0000_0101, len=3, reps=1 → x=1,0,1 on three consecutive x_valid cycles starting one cycle after the handshake; done pulses the following cycle; start_ready returns to 1.
- pattern=3'b001, len=3, reps=3 → x_valid high for 9 cycles with x=0,0,1,0,0,1,0,0,1; a single done pulse. Fed into sequence_detector, the output must match its expected Y/Z sequence.
- len=0, reps=5 → x_valid never asserts; done pulses one cycle after the handshake. Also len=12 with WIDTH=8 → exactly 8 bits sent, equal to pattern[7:0] MSB-first.
- reps=0, len=2, pattern=2'b10 → exactly 2 bits (1,0), treated as reps=1.
- Abort asserted on the 4th bit of a 9-bit burst → x_valid low from the next cycle, no done pulse, IDLE. A start_valid pulse held during SHIFT is ignored, and the burst parameters are not altered.
- resetn pulled low mid-SHIFT → x, x_valid and busy go to 0 immediately without waiting for clk; after release, state is IDLE and a fresh burst runs correctly.

Source files
------------

// File: rtl/seqgen_pkg.sv
// rtl/seqgen_pkg.sv - shared state encoding and default sizes for the pattern generator
package seqgen_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_REPS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial MSB-first pattern transmitter with repeat count and abort
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LEN_W  = $clog2(WIDTH + 1),
    parameter int REPS_W = DEFAULT_REPS_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic [REPS_W-1:0] reps,
    input  logic              abort,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0]  WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0]  ONE_L   = LEN_W'(1);
    localparam logic [REPS_W-1:0] ONE_R   = REPS_W'(1);

    state_e             state_q;
    logic [WIDTH-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [REPS_W-1:0]  reps_q;

    logic [LEN_W-1:0]   len_c;
    logic [REPS_W-1:0]  reps_c;
    logic [WIDTH-1:0]   pat_sh;

    assign len_c  = (len > WIDTH_L) ? WIDTH_L : len;
    assign reps_c = (reps == '0) ? ONE_R : reps;

    // Shift instead of a direct bit select keeps the index width independent of WIDTH.
    assign pat_sh = pat_q >> idx_q;

    // Every output is a decode of flops only; nothing flows straight from the inputs.
    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT);
    assign x_valid     = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign x           = (state_q == ST_SHIFT) & pat_sh[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        pat_q   <= pattern;
                        len_q   <= len_c;
                        reps_q  <= reps_c;
                        idx_q   <= len_c - ONE_L;
                        state_q <= (len_c == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (idx_q != '0) begin
                        idx_q <= idx_q - ONE_L;
                    end else if (reps_q > ONE_R) begin
                        idx_q  <= len_q - ONE_L;
                        reps_q <= reps_q - ONE_R;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - vector table plus scoreboard bench for sequence_generator
module tb_sequence_generator;

    logic       clk;
    logic       resetn;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] p;
        int         l;
        int         r;
        int         abort_at;
        bit         hold;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    sequence_generator dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .reps        (reps),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int el, er, total, exp_n, nb, dn, first_v, last_v, done_at, xbad, extra;
        logic b;
        el      = (v.l > 8) ? 8 : v.l;
        er      = (v.r == 0) ? 1 : v.r;
        total   = el * er;
        exp_n   = (v.abort_at > 0) ? v.abort_at : total;
        nb      = 0;
        dn      = 0;
        first_v = -1;
        last_v  = -1;
        done_at = -1;
        xbad    = 0;
        extra   = 0;
        for (int k = 0; k < exp_n; k++) exp_q.push_back(v.p[el - 1 - (k % el)]);

        @(negedge clk);
        chk({v.nm, ".start_ready_pre"}, int'(start_ready), 1);
        pattern     = v.p;
        len         = 4'(v.l);
        reps        = 4'(v.r);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;

        for (int c = 0; c < total + 6; c++) begin
            if (c > 0) @(negedge clk);
            if (x_valid) begin
                nb++;
                last_v = c;
                if (first_v < 0) first_v = c;
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk($sformatf("%s.bit%0d", v.nm, nb - 1), int'(x), int'(b));
                end else begin
                    extra++;
                end
            end else if (x !== 1'b0) begin
                xbad++;
            end
            if (done) begin
                dn++;
                done_at = c;
            end
            if (v.hold && nb == 1 && x_valid) begin
                start_valid = 1'b1;
                pattern     = ~v.p;
                len         = 4'd2;
                reps        = 4'd1;
            end
            if (v.hold && nb == 3) start_valid = 1'b0;
            abort = (v.abort_at > 0 && nb == v.abort_at && x_valid);
        end
        abort       = 1'b0;
        start_valid = 1'b0;

        chk({v.nm, ".nbits"}, nb, exp_n);
        chk({v.nm, ".extra_bits"}, extra, 0);
        chk({v.nm, ".done_pulses"}, dn, (v.abort_at > 0) ? 0 : 1);
        if (dn > 0) chk({v.nm, ".done_cycle"}, done_at, total);
        if (nb > 0) begin
            chk({v.nm, ".first_valid_latency"}, first_v, 0);
            chk({v.nm, ".valid_contiguous"}, last_v - first_v + 1, nb);
        end
        chk({v.nm, ".x_zero_when_invalid"}, xbad, 0);
        chk({v.nm, ".scoreboard_left"}, exp_q.size(), 0);
        chk({v.nm, ".start_ready_post"}, int'(start_ready), 1);
        exp_q.delete();
    endtask

    initial begin
        vec_t hv;
        resetn      = 1'b0;
        start_valid = 1'b0;
        pattern     = '0;
        len         = '0;
        reps        = '0;
        abort       = 1'b0;

        vecs.push_back('{8'h05, 3,  1, 0, 1'b0, "p101_len3"});
        vecs.push_back('{8'h01, 3,  3, 0, 1'b0, "p001_rep3"});
        vecs.push_back('{8'h00, 0,  5, 0, 1'b0, "len0_rep5"});
        vecs.push_back('{8'hA5, 12, 1, 0, 1'b0, "len12_clamp"});
        vecs.push_back('{8'h02, 2,  0, 0, 1'b0, "reps0"});
        vecs.push_back('{8'hB4, 8,  2, 0, 1'b0, "full_rep2"});
        vecs.push_back('{8'hFF, 1,  4, 0, 1'b0, "len1_rep4"});
        vecs.push_back('{8'h06, 3,  3, 4, 1'b1, "abort4_hold"});
        vecs.push_back('{8'h3C, 6,  2, 0, 1'b0, "after_abort"});

        #12;
        chk("reset.start_ready", int'(start_ready), 1);
        chk("reset.x_valid", int'(x_valid), 0);
        chk("reset.x", int'(x), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_burst(vecs[i]);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        pattern     = 8'h01;
        len         = 4'd3;
        reps        = 4'd3;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.busy_before", int'(busy), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst.x_valid", int'(x_valid), 0);
        chk("midrst.x", int'(x), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.start_ready", int'(start_ready), 1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("midrst.done_after", int'(done), 0);
        chk("midrst.idle_after", int'(start_ready), 1);
        hv = '{8'h05, 3, 2, 0, 1'b0, "post_reset"};
        run_burst(hv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
